// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: picks the next PC source each cycle, handles
// run / single-step / halt debug modes, drives the IF/ID flush and keeps statistics.
module fetch_sequencer #(
  parameter int PC_W         = 10,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run_mode,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             jump_taken,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             instr_is_halt,
  input  logic [PC_W-1:0]  pc,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_next,
  output logic [1:0]       pc_sel,
  output logic             flush_if,
  output logic [1:0]       state,
  output logic             step_done,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALT = 2'b11} stateT;

  localparam int FLUSH_W = 3;

  stateT              stateR, stateNextS;
  logic               stepPendingR, pendNextS;
  logic [FLUSH_W-1:0] flushCntR, flushNextS;
  logic               stepDoneR;
  logic [CNT_W-1:0]   fetchCntR, stallCntR;

  logic               advEnS, pcLoadS, stallS, haltInstrS, redirectS;
  logic [PC_W-1:0]    pcNextS;
  logic [1:0]         pcSelS;

  // Zero-latency advance decision, priority branch > stall > jump > halt opcode > sequential
  always_comb begin
    advEnS     = 1'b0;
    pcLoadS    = 1'b0;
    pcNextS    = pc;
    pcSelS     = 2'b11;
    stallS     = 1'b0;
    haltInstrS = 1'b0;
    redirectS  = 1'b0;
    case (stateR)
      RUN:     advEnS = 1'b1;
      STEP:    advEnS = stepPendingR;
      default: advEnS = 1'b0;
    endcase
    if (advEnS) begin
      if (branch_taken) begin
        pcLoadS   = 1'b1;
        pcNextS   = branch_target;
        pcSelS    = 2'b01;
        redirectS = 1'b1;
      end else if (hazard_stall) begin
        stallS = 1'b1;
      end else if (jump_taken) begin
        pcLoadS   = 1'b1;
        pcNextS   = jump_target;
        pcSelS    = 2'b10;
        redirectS = 1'b1;
      end else if (instr_is_halt) begin
        haltInstrS = 1'b1;
      end else begin
        pcLoadS = 1'b1;
        pcNextS = pc + PC_W'(1);
        pcSelS  = 2'b00;
      end
    end else begin
      pcNextS = pc;
    end
  end

  // Mode transitions, step bookkeeping and flush counter next value
  always_comb begin
    stateNextS = stateR;
    pendNextS  = stepPendingR;
    flushNextS = flushCntR;
    case (stateR)
      IDLE: begin
        if (start) begin
          stateNextS = run_mode ? RUN : STEP;
          pendNextS  = 1'b0;
        end else begin
          stateNextS = IDLE;
        end
      end
      RUN: begin
        if (halt_req || haltInstrS) begin
          stateNextS = HALT;
        end else begin
          stateNextS = RUN;
        end
      end
      STEP: begin
        // halt beats step_req; a completed advance consumes the pending step
        if (halt_req || haltInstrS) begin
          stateNextS = HALT;
          pendNextS  = 1'b0;
        end else if (pcLoadS) begin
          pendNextS = 1'b0;
        end else if (step_req) begin
          pendNextS = 1'b1;
        end else begin
          pendNextS = stepPendingR;
        end
      end
      HALT: begin
        if (resume_req && !halt_req) begin
          stateNextS = run_mode ? RUN : STEP;
          pendNextS  = 1'b0;
        end else begin
          stateNextS = HALT;
        end
      end
      default: begin
        stateNextS = IDLE;
        pendNextS  = 1'b0;
      end
    endcase
    if (stateNextS == HALT || stateNextS == IDLE) begin
      flushNextS = {FLUSH_W{1'b0}};
    end else if (redirectS) begin
      flushNextS = FLUSH_W'(FLUSH_CYCLES);
    end else if (flushCntR != {FLUSH_W{1'b0}}) begin
      flushNextS = flushCntR - FLUSH_W'(1);
    end else begin
      flushNextS = {FLUSH_W{1'b0}};
    end
  end

  // State, step, flush and saturating statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR       <= IDLE;
      stepPendingR <= 1'b0;
      flushCntR    <= {FLUSH_W{1'b0}};
      stepDoneR    <= 1'b0;
      fetchCntR    <= {CNT_W{1'b0}};
      stallCntR    <= {CNT_W{1'b0}};
    end else begin
      stateR       <= stateNextS;
      stepPendingR <= pendNextS;
      flushCntR    <= flushNextS;
      stepDoneR    <= (stateR == STEP) && pcLoadS;
      if (pcLoadS && (fetchCntR != {CNT_W{1'b1}})) begin
        fetchCntR <= fetchCntR + CNT_W'(1);
      end
      if (stallS && (stallCntR != {CNT_W{1'b1}})) begin
        stallCntR <= stallCntR + CNT_W'(1);
      end
    end
  end

  assign pc_load     = pcLoadS;
  assign pc_next     = pcNextS;
  assign pc_sel      = pcSelS;
  assign flush_if    = (flushCntR != {FLUSH_W{1'b0}});
  assign state       = stateR;
  assign step_done   = stepDoneR;
  assign fetch_count = fetchCntR;
  assign stall_count = stallCntR;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected PC loads are queued by the
// stimulus and checked by a negedge monitor; mode/flush/counter checks are inline.
module tb_fetch_sequencer;

  localparam int PC_W = 10;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, run_mode = 1'b0, step_req = 1'b0, halt_req = 1'b0, resume_req = 1'b0;
  logic hazard_stall = 1'b0, branch_taken = 1'b0, jump_taken = 1'b0, instr_is_halt = 1'b0;
  logic [PC_W-1:0] branch_target = '0, jump_target = '0, pc = '0;
  logic pc_load, flush_if, step_done;
  logic [PC_W-1:0] pc_next;
  logic [1:0] pc_sel, state;
  logic [CNT_W-1:0] fetch_count, stall_count;

  typedef struct {
    logic [PC_W-1:0] nxt;
    logic [1:0]      sel;
  } expT;
  expT expQ[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PC_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .run_mode(run_mode), .step_req(step_req),
    .halt_req(halt_req), .resume_req(resume_req), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump_taken(jump_taken),
    .jump_target(jump_target), .instr_is_halt(instr_is_halt), .pc(pc), .pc_load(pc_load),
    .pc_next(pc_next), .pc_sel(pc_sel), .flush_if(flush_if), .state(state),
    .step_done(step_done), .fetch_count(fetch_count), .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectLoad(input logic [PC_W-1:0] nxt, input logic [1:0] sel);
    expT e;
    e.nxt = nxt;
    e.sel = sel;
    expQ.push_back(e);
  endtask

  task automatic chkHold(input string name);
    #1;
    chk({name, "_load"}, 32'(pc_load), 32'd0);
    chk({name, "_sel"}, 32'(pc_sel), 32'd3);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reset && pc_load) begin
          if (expQ.size() == 0) begin
            chk("unexpected_load", 32'(pc_next), 32'hFFFF_FFFF);
          end else begin
            expT e;
            e = expQ.pop_front();
            chk("pc_next", 32'(pc_next), 32'(e.nxt));
            chk("pc_sel", 32'(pc_sel), 32'(e.sel));
          end
        end
      end
    join_none

    // reset state
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_load", 32'(pc_load), 32'd0);
    chk("rst_sel", 32'(pc_sel), 32'd3);
    chk("rst_flush", 32'(flush_if), 32'd0);
    chk("rst_stepdone", 32'(step_done), 32'd0);
    chk("rst_fetch", fetch_count, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_hold", 32'(pc_sel), 32'd3);

    // sequential advance in RUN, then wrap
    run_mode = 1'b1; start = 1'b1; pc = 10'd5;
    tick();
    start = 1'b0;
    chk("run_state", 32'(state), 32'd1);
    expectLoad(10'd6, 2'b00); tick();
    pc = 10'd6; expectLoad(10'd7, 2'b00); tick();
    pc = 10'd7; expectLoad(10'd8, 2'b00); tick();
    chk("fetch_3", fetch_count, 32'd3);
    pc = 10'd1023; expectLoad(10'd0, 2'b00); tick();
    chk("fetch_4", fetch_count, 32'd4);

    // branch beats hazard; flush two cycles
    pc = 10'd100; branch_taken = 1'b1; branch_target = 10'd40; hazard_stall = 1'b1;
    expectLoad(10'd40, 2'b01); tick();
    branch_taken = 1'b0; hazard_stall = 1'b0;
    chk("br_flush1", 32'(flush_if), 32'd1);
    pc = 10'd40; expectLoad(10'd41, 2'b00); tick();
    chk("br_flush2", 32'(flush_if), 32'd1);
    pc = 10'd41; expectLoad(10'd42, 2'b00); tick();
    chk("br_flush_end", 32'(flush_if), 32'd0);
    chk("br_stall", stall_count, 32'd0);
    chk("br_fetch", fetch_count, 32'd7);

    // three stall cycles then jump
    hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chkHold("stall");
      tick();
    end
    chk("stall_3", stall_count, 32'd3);
    hazard_stall = 1'b0; jump_taken = 1'b1; jump_target = 10'd100;
    expectLoad(10'd100, 2'b10); tick();
    jump_taken = 1'b0;
    chk("jmp_flush1", 32'(flush_if), 32'd1);
    pc = 10'd100; expectLoad(10'd101, 2'b00); tick();
    chk("jmp_flush2", 32'(flush_if), 32'd1);
    pc = 10'd101; expectLoad(10'd102, 2'b00); tick();
    chk("jmp_flush_end", 32'(flush_if), 32'd0);

    // asynchronous reset mid-RUN with flush active
    branch_taken = 1'b1; branch_target = 10'd200;
    expectLoad(10'd200, 2'b01); tick();
    branch_taken = 1'b0;
    chk("pre_rst_flush", 32'(flush_if), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_flush", 32'(flush_if), 32'd0);
    chk("arst_fetch", fetch_count, 32'd0);
    chk("arst_stall", stall_count, 32'd0);
    chk("arst_load", 32'(pc_load), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // single-step with stalls, then halt beats step_req
    run_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("step_state", 32'(state), 32'd2);
    chkHold("step_idle");
    pc = 10'd10; step_req = 1'b1; hazard_stall = 1'b1;
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chkHold("step_stall");
      chk("step_nodone", 32'(step_done), 32'd0);
      tick();
    end
    hazard_stall = 1'b0;
    chk("step_nodone2", 32'(step_done), 32'd0);
    expectLoad(10'd11, 2'b00); tick();
    chk("step_done", 32'(step_done), 32'd1);
    chk("step_stallcnt", stall_count, 32'd2);
    chkHold("step_after");
    tick();
    chk("step_done_clr", 32'(step_done), 32'd0);
    step_req = 1'b1; halt_req = 1'b1;
    chkHold("step_halt");
    tick();
    step_req = 1'b0; halt_req = 1'b0;
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_fetch", fetch_count, 32'd1);

    // resume to RUN, halt opcode, halt beats resume, resume to STEP
    run_mode = 1'b1; resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    chk("resume_run", 32'(state), 32'd1);
    pc = 10'd50; instr_is_halt = 1'b1;
    chkHold("halt_op");
    tick();
    instr_is_halt = 1'b0;
    chk("halt_op_state", 32'(state), 32'd3);
    resume_req = 1'b1; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_wins", 32'(state), 32'd3);
    run_mode = 1'b0;
    tick();
    resume_req = 1'b0;
    chk("resume_step", 32'(state), 32'd2);
    chkHold("resume_idle1");
    tick();
    chkHold("resume_idle2");
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    expectLoad(10'd51, 2'b00); tick();
    chk("step2_done", 32'(step_done), 32'd1);
    tick();
    chk("queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
